// File: rtl/tft_sched.sv
// tft_sched: Game Boy LCD pixel stream to 8080-style TFT bus scheduler.
// Buffers 2-bit pixels in a small FIFO and sends each one as two RGB565 bytes.
// Command bursts from a host are passed to the bus at safe points.
// Each bus byte takes two cycles: write strobe low, then high with data held.
// Optional feature macro: TFT_SCHED_WINDOW_EN. When defined, commands are granted
// only at a line boundary, and every burst is followed by a column/row window set
// plus a memory-write command. When undefined, commands are granted only during
// vblank, and the window sequence is absent.
//
// state  | meaning
// IDLE   | bus quiet; pick the next pixel, or a command burst
// PIX_HI | sending the high byte of the current pixel
// PIX_LO | sending the low byte; the raster position advances when it completes
// CMD    | passing host command bytes through; stalls while cmd_valid is low
// WIN    | sending the 11-byte window/memory-write sequence (feature builds only)
module tft_sched #(
    parameter int FIFO_DEPTH = 8,
    parameter int X0         = 40,
    parameter int Y0         = 40,
    parameter int W          = 160,
    parameter int H          = 144
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_vblank,
    input  logic       lcd_write,
    input  logic [1:0] lcd_col,
    input  logic       cmd_valid,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    input  logic       cmd_last,
    output logic       cmd_ready,
    output logic       tft_wr,
    output logic       tft_rs,
    output logic [7:0] tft_data,
    output logic       overflow,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int YW = (H > 1) ? $clog2(H) : 1;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PIX_HI,
        S_PIX_LO,
`ifdef TFT_SCHED_WINDOW_EN
        S_WIN,
`endif
        S_CMD
    } state_t;

    state_t        r_state;
    logic          r_ph;
    logic          r_last;
    logic [1:0]    r_pix;
    logic [1:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wp;
    logic [AW:0]   r_rp;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_vb_d;
`ifdef TFT_SCHED_WINDOW_EN
    logic [3:0]    r_widx;
    logic [7:0]    r_ywin;
`endif

    logic        w_empty;
    logic        w_full;
    logic        w_vb_rise;
    logic        w_pix_done;
    logic        w_grant_ok;
    logic [15:0] w_rgb;

    // GB shade to RGB565
    function automatic logic [15:0] f_rgb(input logic [1:0] c);
        case (c)
            2'b00:   f_rgb = 16'hFFFF;
            2'b01:   f_rgb = 16'hAD55;
            2'b10:   f_rgb = 16'h632C;
            default: f_rgb = 16'h1082;
        endcase
    endfunction

`ifdef TFT_SCHED_WINDOW_EN
    // Window sequence byte {rs, data}; only the row start follows the raster
    function automatic logic [8:0] f_win(input logic [3:0] i, input logic [7:0] yv);
        case (i)
            4'd0:    f_win = {1'b0, 8'h2A};
            4'd1:    f_win = {1'b1, 8'h00};
            4'd2:    f_win = {1'b1, 8'(X0)};
            4'd3:    f_win = {1'b1, 8'h00};
            4'd4:    f_win = {1'b1, 8'(X0 + W - 1)};
            4'd5:    f_win = {1'b0, 8'h2B};
            4'd6:    f_win = {1'b1, 8'h00};
            4'd7:    f_win = {1'b1, 8'(Y0) + yv};
            4'd8:    f_win = {1'b1, 8'h00};
            4'd9:    f_win = {1'b1, 8'(Y0 + H - 1)};
            default: f_win = {1'b0, 8'h2C};
        endcase
    endfunction
`endif

    assign w_empty    = (r_wp == r_rp);
    assign w_full     = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_vb_rise  = lcd_vblank && !r_vb_d;
    assign w_pix_done = (r_state == S_PIX_LO) && r_ph;
    assign w_rgb      = f_rgb(r_pix);
    assign busy       = (r_state != S_IDLE) || !w_empty;
`ifdef TFT_SCHED_WINDOW_EN
    assign w_grant_ok = w_empty && (r_x == '0);
`else
    assign w_grant_ok = w_empty && lcd_vblank;
`endif

    // Pixel FIFO storage; a full FIFO drops the pixel
    always_ff @(posedge clk) begin
        if (lcd_write && !w_full)
            r_mem[r_wp[AW-1:0]] <= lcd_col;
    end

    // FIFO write pointer and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp     <= '0;
            overflow <= 1'b0;
        end else if (lcd_write) begin
            if (w_full)
                overflow <= 1'b1;
            else
                r_wp <= r_wp + PTR_ONE;
        end
    end

    // Raster position of the next pixel; a vblank rising edge restarts the frame
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_vb_d <= 1'b0;
        end else begin
            r_vb_d <= lcd_vblank;
            if (w_vb_rise) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_pix_done) begin
                if (r_x == XW'(W - 1)) begin
                    r_x <= '0;
                    r_y <= (r_y == YW'(H - 1)) ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
        end
    end

    // Scheduler FSM with registered bus outputs; r_ph selects strobe-low vs strobe-high cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ph      <= 1'b0;
            r_last    <= 1'b0;
            r_pix     <= 2'b00;
            r_rp      <= '0;
            tft_wr    <= 1'b1;
            tft_rs    <= 1'b1;
            tft_data  <= 8'h00;
            cmd_ready <= 1'b0;
`ifdef TFT_SCHED_WINDOW_EN
            r_widx    <= 4'd0;
            r_ywin    <= 8'h00;
`endif
        end else begin
            cmd_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ph <= 1'b0;
                    if (!w_empty) begin
                        r_pix   <= r_mem[r_rp[AW-1:0]];
                        r_rp    <= r_rp + PTR_ONE;
                        r_state <= S_PIX_HI;
                    end else if (cmd_valid && w_grant_ok) begin
                        r_state <= S_CMD;
                    end
                end
                S_PIX_HI: begin
                    if (!r_ph) begin
                        tft_wr   <= 1'b0;
                        tft_rs   <= 1'b1;
                        tft_data <= w_rgb[15:8];
                        r_ph     <= 1'b1;
                    end else begin
                        tft_wr  <= 1'b1;
                        r_ph    <= 1'b0;
                        r_state <= S_PIX_LO;
                    end
                end
                S_PIX_LO: begin
                    if (!r_ph) begin
                        tft_wr   <= 1'b0;
                        tft_rs   <= 1'b1;
                        tft_data <= w_rgb[7:0];
                        r_ph     <= 1'b1;
                    end else begin
                        tft_wr <= 1'b1;
                        r_ph   <= 1'b0;
                        // chain straight into the next pixel to keep the 4-cycle cadence
                        if (!w_empty) begin
                            r_pix   <= r_mem[r_rp[AW-1:0]];
                            r_rp    <= r_rp + PTR_ONE;
                            r_state <= S_PIX_HI;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_CMD: begin
                    if (!r_ph) begin
                        if (cmd_valid) begin
                            tft_wr    <= 1'b0;
                            tft_rs    <= cmd_rs;
                            tft_data  <= cmd_data;
                            cmd_ready <= 1'b1;
                            r_last    <= cmd_last;
                            r_ph      <= 1'b1;
                        end
                    end else begin
                        tft_wr <= 1'b1;
                        r_ph   <= 1'b0;
                        if (r_last) begin
`ifdef TFT_SCHED_WINDOW_EN
                            r_widx  <= 4'd0;
                            r_ywin  <= 8'(r_y);
                            r_state <= S_WIN;
`else
                            r_state <= S_IDLE;
`endif
                        end
                    end
                end
`ifdef TFT_SCHED_WINDOW_EN
                S_WIN: begin
                    if (!r_ph) begin
                        tft_wr             <= 1'b0;
                        {tft_rs, tft_data} <= f_win(r_widx, r_ywin);
                        r_ph               <= 1'b1;
                    end else begin
                        tft_wr <= 1'b1;
                        r_ph   <= 1'b0;
                        if (r_widx == 4'd10)
                            r_state <= S_IDLE;
                        else
                            r_widx <= r_widx + 4'd1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
